// File: rtl/tetris_pkg.sv
// tetris_pkg: shared drop-sequencer state type and playfield geometry.
package tetris_pkg;
  localparam int ROW_W = 5;
  localparam int BOARD_ROWS = 20;
  localparam int SPAWN_ROW = 0;
  typedef enum logic [2:0] {SPAWN_CHK, IDLE, CHECK, LOCK, CLEAR, OVER} drop_state_t;
endpackage

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: gravity/drop sequencer (fit check, move or lock, line clear, spawn).
// Optional DROP_TICK_PENDING_EN remembers one drop event arriving while busy.
module piece_drop_ctrl #(
  parameter int ROW_W = tetris_pkg::ROW_W,
  parameter int BOARD_ROWS = tetris_pkg::BOARD_ROWS,
  parameter int SPAWN_ROW = tetris_pkg::SPAWN_ROW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_clk,
  input  logic             pause,
  input  logic             soft_drop,
  output logic             chk_req,
  output logic [ROW_W-1:0] chk_row,
  input  logic             chk_ack,
  input  logic             chk_ok,
  output logic [ROW_W-1:0] piece_row,
  output logic             lock,
  output logic             clear_req,
  input  logic             clear_done,
  output logic             spawn,
  output logic             game_over
);
  import tetris_pkg::*;
  localparam logic [ROW_W-1:0] FLOOR = ROW_W'(BOARD_ROWS - 1);
  localparam logic [ROW_W-1:0] SPAWN = ROW_W'(SPAWN_ROW);
  drop_state_t state;
  logic ev, go, acked;
  assign ev = (game_clk | soft_drop) & !pause;
  assign acked = chk_req & chk_ack;
`ifdef DROP_TICK_PENDING_EN
  logic pending;
  assign go = ev | pending;
  always_ff @(posedge clk)
    if (rst || state == OVER || (state == IDLE && go)) pending <= 1'b0;
    else if (ev && state != IDLE) pending <= 1'b1;
`else
  assign go = ev;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SPAWN_CHK;
      chk_req <= 1'b0;
      chk_row <= '0;
      piece_row <= SPAWN;
      lock <= 1'b0;
      clear_req <= 1'b0;
      spawn <= 1'b0;
      game_over <= 1'b0;
    end else begin
      lock <= 1'b0;
      spawn <= 1'b0;
      case (state)
        SPAWN_CHK:
          if (acked) begin
            chk_req <= 1'b0;
            if (chk_ok) begin
              spawn <= 1'b1;
              piece_row <= SPAWN;
              state <= IDLE;
            end else begin
              game_over <= 1'b1;
              state <= OVER;
            end
          end else begin
            chk_req <= 1'b1;
            chk_row <= SPAWN;
          end
        IDLE:
          if (go) begin
            if (piece_row < FLOOR) begin
              chk_req <= 1'b1;
              chk_row <= piece_row + 1'b1;
              state <= CHECK;
            end else begin
              lock <= 1'b1;
              state <= LOCK;
            end
          end
        CHECK:
          if (acked) begin
            chk_req <= 1'b0;
            if (chk_ok) begin
              piece_row <= chk_row;
              state <= IDLE;
            end else begin
              lock <= 1'b1;
              state <= LOCK;
            end
          end
        LOCK: begin
          clear_req <= 1'b1;
          state <= CLEAR;
        end
        CLEAR:
          if (clear_req && clear_done) begin
            clear_req <= 1'b0;
            state <= SPAWN_CHK;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb_piece_drop_ctrl: directed plus randomized drop rounds against a row-level game model.
module tb_piece_drop_ctrl;
  import tetris_pkg::*;
  logic clk = 0, rst = 1, game_clk = 0, pause = 0, soft_drop = 0;
  logic chk_ack = 0, chk_ok = 0, clear_done = 0;
  logic chk_req, lock, clear_req, spawn, game_over;
  logic [ROW_W-1:0] chk_row, piece_row;
  int passed = 0, total = 0;
  int row;

  always #5 clk = ~clk;

  piece_drop_ctrl dut (
    .clk(clk), .rst(rst), .game_clk(game_clk), .pause(pause), .soft_drop(soft_drop),
    .chk_req(chk_req), .chk_row(chk_row), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .piece_row(piece_row), .lock(lock), .clear_req(clear_req), .clear_done(clear_done),
    .spawn(spawn), .game_over(game_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_drop(input int kind);
    game_clk = (kind != 1);
    soft_drop = (kind != 0);
    step();
    game_clk = 0;
    soft_drop = 0;
  endtask

  task automatic ack(input logic ok);
    chk_ack = 1;
    chk_ok = ok;
    step();
    chk_ack = 0;
    chk_ok = 0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!chk_req && n < 8) begin
      step();
      n++;
    end
    check(tag, chk_req, 1);
  endtask

  task automatic do_spawn(input string tag);
    wait_req({tag, "_req"});
    check({tag, "_chk_row"}, chk_row, SPAWN_ROW);
    ack(1);
    check({tag, "_spawn"}, spawn, 1);
    check({tag, "_piece_row"}, piece_row, SPAWN_ROW);
    check({tag, "_req_low"}, chk_req, 0);
    step();
    check({tag, "_spawn_once"}, spawn, 0);
    row = SPAWN_ROW;
  endtask

  // Called right after the cycle in which lock was seen high.
  task automatic do_clear(input string tag, input int waits);
    step();
    check({tag, "_lock_once"}, lock, 0);
    check({tag, "_clear_req"}, clear_req, 1);
    repeat (waits) begin
      chk_ack = 1;
      chk_ok = 1'($urandom % 2);
      step();
      chk_ack = 0;
      chk_ok = 0;
      check({tag, "_clear_hold"}, clear_req, 1);
    end
    clear_done = 1;
    step();
    clear_done = 0;
    check({tag, "_clear_low"}, clear_req, 0);
  endtask

  task automatic drop_round(input int kind, input int waits, input logic ok);
    pulse_drop(kind);
    if (row == BOARD_ROWS - 1) begin
      check("floor_no_req", chk_req, 0);
      check("floor_lock", lock, 1);
      check("floor_row", piece_row, row);
      do_clear("floor", waits);
      do_spawn("floor_spawn");
    end else begin
      check("drop_req", chk_req, 1);
      check("drop_row", chk_row, row + 1);
      repeat (waits) begin
        chk_ok = 1'($urandom % 2);
        pause = 1'($urandom % 2);
        clear_done = 1'($urandom % 2);
        step();
        check("hold_req", chk_req, 1);
        check("hold_row", chk_row, row + 1);
      end
      chk_ok = 0;
      pause = 0;
      clear_done = 0;
      ack(ok);
      check("ack_req_low", chk_req, 0);
      if (ok) begin
        row++;
        check("moved", piece_row, row);
      end else begin
        check("nofit_lock", lock, 1);
        check("nofit_row", piece_row, row);
        do_clear("nofit", waits);
        do_spawn("nofit_spawn");
      end
    end
  endtask

  initial begin
    rst = 1;
    chk_ack = 1;
    chk_ok = 0;
    step();
    step();
    chk_ack = 0;
    check("rst_chk_req", chk_req, 0);
    check("rst_chk_row", chk_row, 0);
    check("rst_piece_row", piece_row, SPAWN_ROW);
    check("rst_lock", lock, 0);
    check("rst_clear_req", clear_req, 0);
    check("rst_spawn", spawn, 0);
    check("rst_game_over", game_over, 0);
    rst = 0;
    do_spawn("init");
    check("init_no_over", game_over, 0);

    // tick at N, ack at N+2
    drop_round(0, 1, 1);

    pause = 1;
    repeat (3) begin
      pulse_drop($urandom % 3);
      check("pause_no_req", chk_req, 0);
      check("pause_no_lock", lock, 0);
    end
    pause = 0;

    pulse_drop(1);
    check("midpause_req", chk_req, 1);
    pause = 1;
    step();
    check("midpause_hold", chk_req, 1);
    ack(1);
    pause = 0;
    row++;
    check("midpause_moved", piece_row, row);
    check("midpause_req_low", chk_req, 0);

    while (row < BOARD_ROWS - 1) drop_round($urandom % 3, 0, 1);
    check("at_floor", piece_row, BOARD_ROWS - 1);
    drop_round(0, 2, 1);

    // drop event while CLEAR is in progress
    pulse_drop(0);
    ack(0);
    check("tc_lock", lock, 1);
    step();
    check("tc_clear_req", clear_req, 1);
    game_clk = 1;
    step();
    game_clk = 0;
    clear_done = 1;
    step();
    clear_done = 0;
    check("tc_clear_low", clear_req, 0);
    do_spawn("tc_spawn");
`ifdef DROP_TICK_PENDING_EN
    check("pending_req", chk_req, 1);
    check("pending_row", chk_row, SPAWN_ROW + 1);
    ack(1);
    row++;
    check("pending_moved", piece_row, row);
`else
    check("no_pending_req", chk_req, 0);
    step();
    check("no_pending_req2", chk_req, 0);
    check("no_pending_row", piece_row, row);
`endif

    repeat (120) begin
      if ($urandom % 6 == 0) begin
        pause = 1;
        pulse_drop($urandom % 3);
        pause = 0;
        check("rnd_pause_no_req", chk_req, 0);
        check("rnd_pause_row", piece_row, row);
      end else begin
        drop_round($urandom % 3, $urandom % 4, 1'($urandom % 8 != 0));
      end
    end

    pulse_drop(0);
    check("rstmid_req", chk_req, row < BOARD_ROWS - 1);
    rst = 1;
    chk_ack = 1;
    chk_ok = 1;
    step();
    chk_ack = 0;
    chk_ok = 0;
    check("rstmid_chk_req", chk_req, 0);
    check("rstmid_chk_row", chk_row, 0);
    check("rstmid_piece_row", piece_row, SPAWN_ROW);
    check("rstmid_lock", lock, 0);
    check("rstmid_clear_req", clear_req, 0);
    check("rstmid_spawn", spawn, 0);
    check("rstmid_game_over", game_over, 0);
    rst = 0;
    do_spawn("rstmid_spawn");

    pulse_drop(0);
    ack(0);
    check("go_lock", lock, 1);
    do_clear("go", 1);
    wait_req("go_req");
    ack(0);
    check("go_over", game_over, 1);
    check("go_req_low", chk_req, 0);
    check("go_no_spawn", spawn, 0);
    pulse_drop(0);
    pulse_drop(1);
    chk_ack = 1;
    chk_ok = 1;
    clear_done = 1;
    step();
    chk_ack = 0;
    chk_ok = 0;
    clear_done = 0;
    step();
    check("go_sticky", game_over, 1);
    check("go_ignored_req", chk_req, 0);
    check("go_ignored_clear", clear_req, 0);
    check("go_ignored_spawn", spawn, 0);
    rst = 1;
    step();
    rst = 0;
    check("go_rst_clears", game_over, 0);
    do_spawn("go_rst_spawn");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
